sat_rr_sched: RTL and testbench

//   Round-robin scheduler that shares one fixed-point requantize/saturate stage between
//   N_REQ butterfly outputs of an FFT stage. Uses valid/ready on both sides.

---
 rtl/fft_fx_pkg.sv | 24 ++
 rtl/fx_sat_core.sv | 47 ++++
 rtl/sat_rr_sched.sv | 129 ++++++++++++
 tb/tb_sat_rr_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_fx_pkg.sv
// Shared fixed-point definitions for the FFT datapath.
//   - Default Q formats for the butterfly outputs and the requantized words.
//   - Saturation limits for the default output format.
//   - id_width(): index width for a requester count, at least one bit.
package fft_fx_pkg;

    localparam int unsigned N_REQ_DEF     = 4;
    localparam int unsigned NBITS_IN_DEF  = 16;
    localparam int unsigned NBI_IN_DEF    = 4;
    localparam int unsigned NBF_IN_DEF    = 12;
    localparam int unsigned NBITS_OUT_DEF = 8;
    localparam int unsigned NBI_OUT_DEF   = 2;
    localparam int unsigned NBF_OUT_DEF   = 6;
    localparam int unsigned CNT_W_DEF     = 16;

    // Clamp limits for the default output format: most positive and most negative codes.
    localparam logic [NBITS_OUT_DEF-1:0] SAT_MAX_DEF = {1'b0, {(NBITS_OUT_DEF-1){1'b1}}};
    localparam logic [NBITS_OUT_DEF-1:0] SAT_MIN_DEF = {1'b1, {(NBITS_OUT_DEF-1){1'b0}}};

    function automatic int unsigned id_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fx_sat_core.sv
// Combinational requantize/saturate of one signed fixed-point word.
//   x   : input word, Q(NBI_IN.NBF_IN)
//   y   : output word, Q(NBI_OUT.NBF_OUT), fraction truncated (no rounding)
//   sat : y was clamped to the positive or negative limit
module fx_sat_core
    import fft_fx_pkg::*;
#(
    parameter int unsigned NBITS_IN  = NBITS_IN_DEF,
    parameter int unsigned NBF_IN    = NBF_IN_DEF,
    parameter int unsigned NBITS_OUT = NBITS_OUT_DEF,
    parameter int unsigned NBI_OUT   = NBI_OUT_DEF
) (
    input  logic [NBITS_IN-1:0]  x,
    output logic [NBITS_OUT-1:0] y,
    output logic                 sat
);

    localparam int unsigned TOP   = NBF_IN + NBI_OUT - 1;
    localparam int unsigned GRD_W = NBITS_IN - TOP;

    // The discarded integer bits plus the new sign bit must all agree, otherwise the
    // value does not fit in the narrower integer field.
    logic [GRD_W-1:0] guard;
    logic             fits;

    assign guard = x[NBITS_IN-1:TOP];
    assign fits  = (&guard) | ~(|guard);

    always_comb begin
        y   = x[TOP -: NBITS_OUT];
        sat = 1'b0;
        if (!fits) begin
            sat = 1'b1;
            y   = x[NBITS_IN-1] ? {1'b1, {(NBITS_OUT-1){1'b0}}}
                                : {1'b0, {(NBITS_OUT-1){1'b1}}};
        end
    end

    // Fraction bits below the output LSB are truncated away.
    generate
        if (TOP + 1 > NBITS_OUT) begin : g_trunc
            logic unused_lsb;
            assign unused_lsb = ^x[TOP-NBITS_OUT:0];
        end
    endgenerate

endmodule

// File: rtl/sat_rr_sched.sv
// Round-robin scheduler sharing one requantize/saturate stage between N_REQ requesters.
//   clk, rst_n              : clock, async active-low reset
//   i_req_valid/i_req_data  : per-requester valid and packed input words
//   o_req_ready             : one-hot accept (zero when the output register is blocked)
//   o_valid/o_data/o_id/o_sat, i_out_ready : registered result with source index
//   i_cnt_clr, o_sat_cnt    : clear and packed per-requester saturation counters
module sat_rr_sched
    import fft_fx_pkg::*;
#(
    parameter int unsigned N_REQ     = N_REQ_DEF,
    parameter int unsigned NBITS_IN  = NBITS_IN_DEF,
    parameter int unsigned NBI_IN    = NBI_IN_DEF,
    parameter int unsigned NBF_IN    = NBF_IN_DEF,
    parameter int unsigned NBITS_OUT = NBITS_OUT_DEF,
    parameter int unsigned NBI_OUT   = NBI_OUT_DEF,
    parameter int unsigned NBF_OUT   = NBF_OUT_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              i_req_valid,
    input  logic [N_REQ*NBITS_IN-1:0]     i_req_data,
    output logic [N_REQ-1:0]              o_req_ready,
    output logic                          o_valid,
    output logic [NBITS_OUT-1:0]          o_data,
    output logic [id_width(N_REQ)-1:0]    o_id,
    output logic                          o_sat,
    input  logic                          i_out_ready,
    input  logic                          i_cnt_clr,
    output logic [N_REQ*CNT_W-1:0]        o_sat_cnt
);

    localparam int unsigned ID_W = id_width(N_REQ);

    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      gnt_idx;
    logic [N_REQ-1:0]     gnt_oh;
    logic                 gnt_found;
    logic                 load, accept;
    logic [NBITS_IN-1:0]  sel_data;
    logic [NBITS_OUT-1:0] sat_y;
    logic                 sat_flag;
    logic [CNT_W-1:0]     cnt_q [N_REQ];

    // Output register may take a new item when empty or being drained this cycle.
    assign load   = ~o_valid | i_out_ready;
    assign accept = load & gnt_found;

    // First valid requester at or after ptr_q, wrapping modulo N_REQ.
    always_comb begin
        int unsigned j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_oh    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = (32'(ptr_q) + i) % N_REQ;
            if (!gnt_found && i_req_valid[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(j);
                gnt_oh[j] = 1'b1;
            end
        end
    end

    assign o_req_ready = load ? gnt_oh : '0;
    assign ptr_d       = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gnt_oh[k]) sel_data = i_req_data[k*NBITS_IN +: NBITS_IN];
        end
    end

    fx_sat_core #(
        .NBITS_IN  (NBITS_IN),
        .NBF_IN    (NBF_IN),
        .NBITS_OUT (NBITS_OUT),
        .NBI_OUT   (NBI_OUT)
    ) u_sat (
        .x   (sel_data),
        .y   (sat_y),
        .sat (sat_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_id    <= '0;
            o_sat   <= 1'b0;
        end else if (load) begin
            o_valid <= gnt_found;
            if (gnt_found) begin
                ptr_q  <= ptr_d;
                o_data <= sat_y;
                o_id   <= gnt_idx;
                o_sat  <= sat_flag;
            end
        end
    end

    // Saturating event counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_REQ; k++) cnt_q[k] <= '0;
        end else if (i_cnt_clr) begin
            for (int unsigned k = 0; k < N_REQ; k++) cnt_q[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (accept && sat_flag && gnt_oh[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_sat_cnt = '0;
        for (int unsigned k = 0; k < N_REQ; k++) o_sat_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end

    // Format parameters kept for interface completeness; the core derives what it needs.
    logic unused_fmt;
    assign unused_fmt = ^{NBI_IN[0], NBF_OUT[0]};

endmodule

// File: tb/tb_sat_rr_sched.sv
module tb_sat_rr_sched;
    import fft_fx_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic        out_ready;
    logic        cnt_clr;

    logic [3:0]  rdy_b, rdy_s;
    logic        val_b, val_s;
    logic [7:0]  dat_b, dat_s;
    logic [1:0]  id_b, id_s;
    logic        sat_b, sat_s;
    logic [63:0] cnt_b;
    logic [7:0]  cnt_s;

    int checks;
    int failures;

    sat_rr_sched u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (rdy_b),
        .o_valid     (val_b),
        .o_data      (dat_b),
        .o_id        (id_b),
        .o_sat       (sat_b),
        .i_out_ready (out_ready),
        .i_cnt_clr   (cnt_clr),
        .o_sat_cnt   (cnt_b)
    );

    sat_rr_sched #(.CNT_W(2)) u_dut_c2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (rdy_s),
        .o_valid     (val_s),
        .o_data      (dat_s),
        .o_id        (id_s),
        .o_sat       (sat_s),
        .i_out_ready (out_ready),
        .i_cnt_clr   (cnt_clr),
        .o_sat_cnt   (cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned id;
        logic [15:0] din;
        logic [7:0]  dout;
        logic        sat;
    } vec_t;

    vec_t vecs[10];
    int   exp_cnt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cb(input int k);
        return cnt_b[k*16 +: 16];
    endfunction

    function automatic logic [1:0] cs(input int k);
        return cnt_s[k*2 +: 2];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        vecs[0] = '{0, 16'h0400, 8'h10, 1'b0};
        vecs[1] = '{1, 16'h3000, SAT_MAX_DEF, 1'b1};
        vecs[2] = '{2, 16'hD000, SAT_MIN_DEF, 1'b1};
        vecs[3] = '{3, 16'hF800, 8'hE0, 1'b0};
        vecs[4] = '{0, 16'h1FC0, 8'h7F, 1'b0};
        vecs[5] = '{1, 16'h2000, 8'h7F, 1'b1};
        vecs[6] = '{2, 16'hE000, 8'h80, 1'b0};
        vecs[7] = '{3, 16'hDFFF, 8'h80, 1'b1};
        vecs[8] = '{0, 16'hFFFF, 8'hFF, 1'b0};
        vecs[9] = '{1, 16'h003F, 8'h00, 1'b0};
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;

        tick();
        tick();
        chk("reset_valid", 32'(val_b), 0);
        chk("reset_data", 32'(dat_b), 0);
        chk("reset_id", 32'(id_b), 0);
        chk("reset_sat", 32'(sat_b), 0);
        chk("reset_cnt", cnt_b[31:0] | cnt_b[63:32], 0);
        rst_n = 1'b1;
        tick();

        // Single-requester transactions through the requantizer.
        for (int v = 0; v < 10; v++) begin
            req_data = '0;
            req_data[vecs[v].id*16 +: 16] = vecs[v].din;
            req_valid = 4'(1 << vecs[v].id);
            #1;
            chk($sformatf("v%0d_ready", v), 32'(rdy_b), 32'(1 << vecs[v].id));
            tick();
            req_valid = '0;
            if (vecs[v].sat) exp_cnt[vecs[v].id]++;
            chk($sformatf("v%0d_valid", v), 32'(val_b), 1);
            chk($sformatf("v%0d_data", v), 32'(dat_b), 32'(vecs[v].dout));
            chk($sformatf("v%0d_id", v), 32'(id_b), vecs[v].id);
            chk($sformatf("v%0d_sat", v), 32'(sat_b), 32'(vecs[v].sat));
            tick();
            chk($sformatf("v%0d_drain", v), 32'(val_b), 0);
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tbl_cnt_b%0d", k), 32'(cb(k)), exp_cnt[k]);
            chk($sformatf("tbl_cnt_s%0d", k), 32'(cs(k)), exp_cnt[k]);
        end

        // Round-robin with all requesters valid: one result per cycle, ids 0,1,2,3,...
        do_reset();
        for (int k = 0; k < 4; k++) req_data[k*16 +: 16] = 16'(k * 16'h0040);
        req_valid = 4'hF;
        #1;
        chk("rr_first_ready", 32'(rdy_b), 1);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("rr%0d_valid", c), 32'(val_b), 1);
            chk($sformatf("rr%0d_id", c), 32'(id_b), c % 4);
            chk($sformatf("rr%0d_data", c), 32'(dat_b), c % 4);
        end

        // Back-pressure: output held, nothing accepted.
        out_ready = 1'b0;
        #1;
        chk("stall_ready0", 32'(rdy_b), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d_valid", c), 32'(val_b), 1);
            chk($sformatf("stall%0d_id", c), 32'(id_b), 3);
            chk($sformatf("stall%0d_data", c), 32'(dat_b), 3);
            chk($sformatf("stall%0d_ready", c), 32'(rdy_b), 0);
        end
        // Drain and accept in the same cycle.
        out_ready = 1'b1;
        #1;
        chk("resume_ready", 32'(rdy_b), 1);
        tick();
        chk("resume_valid", 32'(val_b), 1);
        chk("resume_id", 32'(id_b), 0);
        req_valid = '0;
        tick();
        chk("drain_no_accept", 32'(val_b), 0);

        // Counter saturation with a 2-bit counter, then clear vs. increment.
        do_reset();
        req_data  = '0;
        req_data[15:0] = 16'h3000;
        req_valid = 4'h1;
        for (int c = 0; c < 4; c++) tick();
        chk("stick_cnt_s0", 32'(cs(0)), 3);
        chk("stick_cnt_b0", 32'(cb(0)), 4);
        chk("stick_sat", 32'(sat_b), 1);
        chk("stick_data", 32'(dat_b), 32'h7F);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_cnt_s0", 32'(cs(0)), 0);
        chk("clr_cnt_b0", 32'(cb(0)), 0);
        chk("clr_accept_valid", 32'(val_b), 1);
        tick();
        chk("post_clr_cnt_s0", 32'(cs(0)), 1);
        chk("post_clr_cnt_b0", 32'(cb(0)), 1);

        // Asynchronous reset mid-stream.
        for (int k = 0; k < 4; k++) req_data[k*16 +: 16] = 16'h3000;
        req_valid = 4'hF;
        for (int c = 0; c < 3; c++) tick();
        chk("pre_rst_valid", 32'(val_b), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(val_b), 0);
        chk("async_rst_cnt_b", cnt_b[31:0] | cnt_b[63:32], 0);
        chk("async_rst_cnt_s", 32'(cnt_s), 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_id0", 32'(id_b), 0);
        chk("post_rst_valid", 32'(val_b), 1);
        tick();
        chk("post_rst_id1", 32'(id_b), 1);
        req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
